hamming_rx_ctrl: RTL and testbench
==================================

// Module: hamming_rx_ctrl
// PURPOSE
//   Receive-side sequencer for the Hamming(13,8) SECDED link over UART.
//   Assembles two received UART bytes into one 13-bit codeword, then runs it through an internal SECDED decode stage.
//   Presents the corrected byte on a valid/ready interface and maintains saturating error/frame statistics.
//   Sits between the UART RX byte output and the consumer logic.
// PARAMETERS
//   TIMEOUT_CYC  1024  max clk cycles allowed between low and high byte of a frame
//   HDR          3'b101 required value of high byte [7:5] (frame sync marker)
//   DROP_DOUBLE  1     1: discard uncorrectable frames; 0: forward them flagged
// PORTS
//   clk            in   1  system clock, all state on rising edge
//   rst            in   1  asynchronous, active-high reset
//   rx_byte        in   8  byte from UART RX
//   rx_valid       in   1  one-cycle strobe, rx_byte valid
//   out_data       out  8  decoded/corrected data byte
//   out_valid      out  1  out_data valid, held until accepted
//   out_ready      in   1  consumer accepts when out_valid&&out_ready
//   out_err_single out  1  frame had a corrected single-bit error (qualifies out_valid)
//   out_err_double out  1  frame uncorrectable (only when DROP_DOUBLE=0)
//   clr_cnt        in   1  synchronous clear of all counters
//   cnt_single     out  8  corrected-frame count, saturates at 255
//   cnt_double     out  8  uncorrectable-frame count, saturates at 255
//   cnt_frame      out  8  timeout + bad-header count, saturates at 255
//   cnt_overrun    out  8  bytes dropped while busy, saturates at 255
// BEHAVIOUR
//   Reset: state=WAIT_LO; all outputs, code reg, timeout counter = 0.
//   Codeword: low byte = code[7:0]; high byte = {HDR, code[12:8]}.
//   Bit mapping (code[i] = position i+1):
//     p1,p2,d1,p4,d2,d3,d4,p8,d5,d6,d7,d8,p_total.
//   Decode stage: even-parity syndrome {s8,s4,s2,s1} plus overall parity.
//     - syn!=0 && overall=1: single error, flip bit syn-1.
//     - syn=0 && overall=1: single error in p_total.
//     - syn!=0 && overall=0: double error.
//   FSM:
//     WAIT_LO: rx_valid -> latch code[7:0], clear timer, go WAIT_HI.
//     WAIT_HI: each cycle without rx_valid, timer++.
//       Timer reaching TIMEOUT_CYC-1: go WAIT_LO, cnt_frame++.
//       rx_valid with [7:5]==HDR: latch code[12:8], go DECODE.
//       rx_valid with [7:5]!=HDR: go WAIT_LO, cnt_frame++ (byte discarded).
//       rx_valid on the timeout cycle: byte wins, timeout is ignored.
//     DECODE (1 cycle): register decode results.
//       Double error && DROP_DOUBLE=1: go WAIT_LO, cnt_double++, out_valid stays 0.
//       Otherwise: go HOLD, out_valid=1, data and flags registered; bump cnt_single/cnt_double as applicable.
//     HOLD: out_data and flags stable while out_valid=1.
//       out_ready=1: transfer at that edge; out_valid=0 next cycle; go WAIT_LO.
//   Latency: high byte sampled at edge E -> out_valid high after edge E+1 (2 cycles after rx_valid).
//   Overrun: rx_valid in DECODE or HOLD drops the byte, cnt_overrun++; it never starts a frame.
//   Counters: saturate at 255 (no wrap). clr_cnt beats any same-cycle increment (result 0).
//   Reset mid-frame: partial codeword discarded; no out_valid; counters cleared.
//   Outputs are registered; no combinational path rx_* -> out_*.
// TESTING
//   Clean frame: rx 0x27, then 0xAA, ready=1 -> out_data=0xA5 two cycles later; err flags 0; counters 0.
//   Single error: rx 0x37, then 0xAA -> out_data=0xA5, out_err_single=1, cnt_single=1.
//   Double error: rx 0x24, then 0xAA.
//     DROP_DOUBLE=1 -> no out_valid, cnt_double=1.
//     DROP_DOUBLE=0 -> out_valid with out_err_double=1.
//   Timeout/header:
//     rx 0x27, idle TIMEOUT_CYC cycles -> cnt_frame=1, FSM back in WAIT_LO.
//     rx 0x27, then 0x0A (bad header) -> cnt_frame=2, no output.
//   Backpressure: hold out_ready=0, send a valid frame, then 3 more bytes.
//     -> out_data stays 0xA5, cnt_overrun=3; ready=1 -> single transfer.
//   Saturation/clear/reset: 300 single-error frames -> cnt_single=255.
//     clr_cnt with a same-cycle increment -> 0.
//     rst asserted between low and high byte -> no output; next clean frame decodes correctly.

Source files
------------

// File: rtl/hamming_rx_ctrl_if.sv
// Purpose : byte-in / decoded-byte-out bundle for the Hamming(13,8) receive sequencer.
// Latency : n/a (wires only).
// Backpressure: out_valid/out_ready handshake; rx side is a strobe with no backpressure.
// Ports   : rx_byte/rx_valid (UART RX byte strobe), out_data/out_valid/out_ready (decoded byte),
//           out_err_single/out_err_double (status flags qualified by out_valid).
interface hamming_rx_ctrl_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_err_single;
    logic       out_err_double;

    // master: the side feeding bytes in and consuming decoded bytes
    modport master (
        output rx_byte, rx_valid, out_ready,
        input  out_data, out_valid, out_err_single, out_err_double
    );

    // slave: the sequencer itself
    modport slave (
        input  rx_byte, rx_valid, out_ready,
        output out_data, out_valid, out_err_single, out_err_double
    );
endinterface

// File: rtl/hamming_rx_ctrl.sv
// Purpose : assembles two UART bytes into a Hamming(13,8) SECDED codeword, decodes it, keeps error stats.
// Latency : high byte sampled at edge E -> out_valid high after edge E+1; all outputs registered.
// Backpressure: out_valid held until out_ready; bytes arriving while decoding/holding are dropped and counted.
// Ports   : clk, rst (async active-high); bus (hamming_rx_ctrl_if.slave); clr_cnt_i (sync counter clear);
//           cnt_single_o, cnt_double_o, cnt_frame_o, cnt_overrun_o (8-bit saturating statistics).
module hamming_rx_ctrl #(
    parameter int         TIMEOUT_CYC = 1024,
    parameter logic [2:0] HDR         = 3'b101,
    parameter bit         DROP_DOUBLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    hamming_rx_ctrl_if.slave  bus,
    input  logic              clr_cnt_i,
    output logic [7:0]        cnt_single_o,
    output logic [7:0]        cnt_double_o,
    output logic [7:0]        cnt_frame_o,
    output logic [7:0]        cnt_overrun_o
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {WAIT_LO, WAIT_HI, DECODE, HOLD} state_t;

    state_t        state_q, state_d;
    logic [12:0]   code_q, code_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          err_single_q, err_single_d;
    logic          err_double_q, err_double_d;
    logic [7:0]    cnt_single_q, cnt_single_d;
    logic [7:0]    cnt_double_q, cnt_double_d;
    logic [7:0]    cnt_frame_q, cnt_frame_d;
    logic [7:0]    cnt_overrun_q, cnt_overrun_d;

    logic inc_single, inc_double, inc_frame, inc_overrun;

    // SECDED decode of the assembled codeword (code[i] is Hamming position i+1)
    logic [3:0]  syn;
    logic        overall;
    logic [12:0] fixed;
    logic        dec_single, dec_double;
    logic [7:0]  dec_data;

    always_comb begin
        syn[0]  = ^{code_q[0], code_q[2], code_q[4], code_q[6], code_q[8], code_q[10]};
        syn[1]  = ^{code_q[1], code_q[2], code_q[5], code_q[6], code_q[9], code_q[10]};
        syn[2]  = ^{code_q[3], code_q[4], code_q[5], code_q[6], code_q[11]};
        syn[3]  = ^{code_q[7], code_q[8], code_q[9], code_q[10], code_q[11]};
        overall = ^code_q;
        fixed   = code_q;
        // Syndromes 14/15 point past the codeword: with odd overall parity that can
        // only be a multi-bit error, so it is reported as uncorrectable.
        dec_single = overall && (syn <= 4'd13);
        dec_double = (!overall && (syn != 4'd0)) || (overall && (syn > 4'd13));
        if (overall) begin
            for (int i = 0; i < 13; i++) begin
                if (syn == 4'(i + 1)) fixed[i] = ~fixed[i];
            end
        end
        dec_data = {fixed[11], fixed[10], fixed[9], fixed[8],
                    fixed[6],  fixed[5],  fixed[4], fixed[2]};
    end

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        timer_d      = timer_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        err_single_d = err_single_q;
        err_double_d = err_double_q;
        inc_single   = 1'b0;
        inc_double   = 1'b0;
        inc_frame    = 1'b0;
        inc_overrun  = 1'b0;

        case (state_q)
            WAIT_LO: begin
                if (bus.rx_valid) begin
                    code_d[7:0] = bus.rx_byte;
                    timer_d     = '0;
                    state_d     = WAIT_HI;
                end
            end
            WAIT_HI: begin
                // A byte arriving on the timeout cycle takes priority over the timeout.
                if (bus.rx_valid) begin
                    if (bus.rx_byte[7:5] == HDR) begin
                        code_d[12:8] = bus.rx_byte[4:0];
                        state_d      = DECODE;
                    end else begin
                        inc_frame = 1'b1;
                        state_d   = WAIT_LO;
                    end
                end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    inc_frame = 1'b1;
                    state_d   = WAIT_LO;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DECODE: begin
                inc_overrun = bus.rx_valid;
                if (dec_double && DROP_DOUBLE) begin
                    inc_double = 1'b1;
                    state_d    = WAIT_LO;
                end else begin
                    out_valid_d  = 1'b1;
                    out_data_d   = dec_data;
                    err_single_d = dec_single;
                    err_double_d = dec_double;
                    inc_single   = dec_single;
                    inc_double   = dec_double;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                inc_overrun = bus.rx_valid;
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = WAIT_LO;
                end
            end
            default: state_d = WAIT_LO;
        endcase

        // Clear wins over any increment landing in the same cycle.
        cnt_single_d  = clr_cnt_i ? 8'd0 : (inc_single  ? sat_inc(cnt_single_q)  : cnt_single_q);
        cnt_double_d  = clr_cnt_i ? 8'd0 : (inc_double  ? sat_inc(cnt_double_q)  : cnt_double_q);
        cnt_frame_d   = clr_cnt_i ? 8'd0 : (inc_frame   ? sat_inc(cnt_frame_q)   : cnt_frame_q);
        cnt_overrun_d = clr_cnt_i ? 8'd0 : (inc_overrun ? sat_inc(cnt_overrun_q) : cnt_overrun_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= WAIT_LO;
            code_q        <= '0;
            timer_q       <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            err_single_q  <= 1'b0;
            err_double_q  <= 1'b0;
            cnt_single_q  <= '0;
            cnt_double_q  <= '0;
            cnt_frame_q   <= '0;
            cnt_overrun_q <= '0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            timer_q       <= timer_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            err_single_q  <= err_single_d;
            err_double_q  <= err_double_d;
            cnt_single_q  <= cnt_single_d;
            cnt_double_q  <= cnt_double_d;
            cnt_frame_q   <= cnt_frame_d;
            cnt_overrun_q <= cnt_overrun_d;
        end
    end

    assign bus.out_data       = out_data_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_err_single = err_single_q;
    assign bus.out_err_double = err_double_q;
    assign cnt_single_o       = cnt_single_q;
    assign cnt_double_o       = cnt_double_q;
    assign cnt_frame_o        = cnt_frame_q;
    assign cnt_overrun_o      = cnt_overrun_q;

endmodule

// File: tb/tb_hamming_rx_ctrl.sv
// Purpose : directed bench for hamming_rx_ctrl; a second instance with DROP_DOUBLE=0 shares the stimulus.
// Latency : inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: out_ready driven directly by the stimulus.
module tb_hamming_rx_ctrl;
    localparam int TO = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr_cnt;
    logic [7:0] cnt_single, cnt_double, cnt_frame, cnt_overrun;
    logic [7:0] cnt_single2, cnt_double2, cnt_frame2, cnt_overrun2;

    int n_vec = 0;
    int n_err = 0;
    int xfers;

    hamming_rx_ctrl_if bus();
    hamming_rx_ctrl_if bus2();

    assign bus2.rx_byte   = bus.rx_byte;
    assign bus2.rx_valid  = bus.rx_valid;
    assign bus2.out_ready = bus.out_ready;

    always #5 clk = ~clk;

    hamming_rx_ctrl #(.TIMEOUT_CYC(TO), .HDR(3'b101), .DROP_DOUBLE(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus), .clr_cnt_i(clr_cnt),
        .cnt_single_o(cnt_single), .cnt_double_o(cnt_double),
        .cnt_frame_o(cnt_frame), .cnt_overrun_o(cnt_overrun)
    );

    hamming_rx_ctrl #(.TIMEOUT_CYC(TO), .HDR(3'b101), .DROP_DOUBLE(1'b0)) dut_fwd (
        .clk(clk), .rst(rst), .bus(bus2), .clr_cnt_i(clr_cnt),
        .cnt_single_o(cnt_single2), .cnt_double_o(cnt_double2),
        .cnt_frame_o(cnt_frame2), .cnt_overrun_o(cnt_overrun2)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        tick(1);
        bus.rx_valid = 1'b0;
    endtask

    // Full frame with out_ready=1: checks 2-cycle latency, payload, flags and the one-cycle handshake.
    task automatic frame_out(input string tag, input logic [7:0] lo, input logic [7:0] hi,
                             input logic [7:0] data, input logic es, input logic ed);
        send(lo);
        send(hi);
        @(negedge clk);
        chk({tag, "_lat"}, 8'(bus.out_valid), 8'd0);
        tick(1);
        @(negedge clk);
        chk({tag, "_vld"}, 8'(bus.out_valid), 8'd1);
        chk({tag, "_dat"}, bus.out_data, data);
        chk({tag, "_es"},  8'(bus.out_err_single), 8'(es));
        chk({tag, "_ed"},  8'(bus.out_err_double), 8'(ed));
        tick(1);
        @(negedge clk);
        chk({tag, "_drop"}, 8'(bus.out_valid), 8'd0);
        tick(1);
    endtask

    initial begin
        bus.rx_byte   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.out_ready = 1'b1;
        clr_cnt       = 1'b0;
        rst           = 1'b1;
        tick(2);
        @(negedge clk);
        chk("rst_vld", 8'(bus.out_valid), 8'd0);
        chk("rst_dat", bus.out_data, 8'h00);
        chk("rst_cnt", cnt_single | cnt_double | cnt_frame | cnt_overrun, 8'h00);
        rst = 1'b0;
        tick(1);

        // Clean codeword 0x0A27 -> 0xA5
        frame_out("clean", 8'h27, 8'hAA, 8'hA5, 1'b0, 1'b0);
        chk("clean_cs", cnt_single, 8'd0);
        chk("clean_cd", cnt_double, 8'd0);
        chk("clean_cf", cnt_frame, 8'd0);
        chk("clean_co", cnt_overrun, 8'd0);

        // d2 (position 5) flipped -> corrected
        frame_out("single", 8'h37, 8'hAA, 8'hA5, 1'b1, 1'b0);
        chk("single_cs", cnt_single, 8'd1);

        // p1+p2 flipped -> uncorrectable: dropped by dut, forwarded flagged by dut_fwd
        send(8'h24);
        send(8'hAA);
        @(negedge clk);
        tick(1);
        @(negedge clk);
        chk("dbl_drop_vld", 8'(bus.out_valid), 8'd0);
        chk("dbl_fwd_vld", 8'(bus2.out_valid), 8'd1);
        chk("dbl_fwd_ed", 8'(bus2.out_err_double), 8'd1);
        chk("dbl_fwd_es", 8'(bus2.out_err_single), 8'd0);
        tick(1);
        chk("dbl_cd", cnt_double, 8'd1);
        chk("dbl_fwd_cd", cnt_double2, 8'd1);
        tick(1);

        // Timeout boundary: fires on the TO-th idle edge, not before
        send(8'h27);
        tick(TO - 1);
        @(negedge clk);
        chk("to_early_cf", cnt_frame, 8'd0);
        tick(1);
        @(negedge clk);
        chk("to_cf", cnt_frame, 8'd1);
        tick(1);
        frame_out("after_to", 8'h27, 8'hAA, 8'hA5, 1'b0, 1'b0);

        // High byte on the timeout cycle wins
        send(8'h27);
        tick(TO - 1);
        send(8'hAA);
        @(negedge clk);
        tick(1);
        @(negedge clk);
        chk("win_vld", 8'(bus.out_valid), 8'd1);
        chk("win_dat", bus.out_data, 8'hA5);
        chk("win_cf", cnt_frame, 8'd1);
        tick(2);

        // Bad header
        send(8'h27);
        send(8'h0A);
        @(negedge clk);
        chk("hdr_cf", cnt_frame, 8'd2);
        repeat (3) begin
            tick(1);
            @(negedge clk);
            chk("hdr_vld", 8'(bus.out_valid), 8'd0);
        end
        tick(1);

        // Backpressure with three overrun bytes
        bus.out_ready = 1'b0;
        send(8'h27);
        send(8'hAA);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        tick(3);
        @(negedge clk);
        chk("bp_vld", 8'(bus.out_valid), 8'd1);
        chk("bp_dat", bus.out_data, 8'hA5);
        chk("bp_co", cnt_overrun, 8'd3);
        tick(1);
        bus.out_ready = 1'b1;
        xfers = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) xfers++;
        end
        chk("bp_xfers", 8'(xfers), 8'd1);
        tick(1);

        // Clear, then saturation
        clr_cnt = 1'b1;
        tick(1);
        clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_cs", cnt_single, 8'd0);
        chk("clr_co", cnt_overrun, 8'd0);
        tick(1);
        repeat (300) begin
            send(8'h37);
            send(8'hAA);
            tick(3);
        end
        @(negedge clk);
        chk("sat_cs", cnt_single, 8'd255);
        tick(1);

        // Clear coinciding with an increment
        send(8'h37);
        send(8'hAA);
        clr_cnt = 1'b1;
        tick(1);
        clr_cnt = 1'b0;
        @(negedge clk);
        chk("clrinc_vld", 8'(bus.out_valid), 8'd1);
        chk("clrinc_cs", cnt_single, 8'd0);
        tick(2);

        // Reset between low and high byte
        frame_out("pre_rst", 8'h37, 8'hAA, 8'hA5, 1'b1, 1'b0);
        send(8'h27);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_vld", 8'(bus.out_valid), 8'd0);
        chk("midrst_cs", cnt_single, 8'd0);
        chk("midrst_cf", cnt_frame, 8'd0);
        tick(2);
        frame_out("post_rst", 8'h27, 8'hAA, 8'hA5, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
